spu_issue_buffer: RTL and testbench

- Consumer end of the instruction-fetch interface. Captures the 64-bit instruction pair that fetch presents each cycle and buffers pairs in a small FIFO.
- Drives fetch's PC-advance enable as backpressure and splits each pair into even-pipe and odd-pipe issue slots. Serializes a pair when it cannot dual-issue.
- Flushes on branch redirect and tracks the 11-bit byte PC of every issued instruction.

---
 rtl/spu_issue_pkg.sv | 40 ++++
 rtl/spu_pair_fifo.sv | 72 +++++++
 rtl/spu_issue_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_spu_issue_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_issue_pkg.sv
// Shared types and decode helpers for the SPU issue buffer.
// PC_W is fixed here because it must match the fetch unit's byte-PC width.
package spu_issue_pkg;

    localparam int PC_W = 11;

    typedef struct packed {
        logic [31:0]     first;
        logic [31:0]     second;
        logic [PC_W-1:0] pc;
        logic            skip_first;
    } pair_entry_t;

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } issue_state_t;

    function automatic logic is_odd_pipe(input logic [31:0] instr);
        return (instr[31:28] == 4'b0010) || (instr[31:28] == 4'b0011);
    endfunction

    function automatic logic [6:0] rt_field(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [6:0] ra_field(input logic [31:0] instr);
        return instr[13:7];
    endfunction

    function automatic logic [6:0] rb_field(input logic [31:0] instr);
        return instr[20:14];
    endfunction

    // Second word reads a register the first word writes.
    function automatic logic depends_on(input logic [31:0] first, input logic [31:0] second);
        return (rt_field(first) == ra_field(second)) || (rt_field(first) == rb_field(second));
    endfunction

endpackage

// File: rtl/spu_pair_fifo.sv
// Circular FIFO of instruction pairs with async reset and synchronous flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module spu_pair_fifo
    import spu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  pair_entry_t              wdata_i,
    output pair_entry_t              rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    pair_entry_t     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spu_issue_buffer.sv
// Issue buffer: captures fetched instruction pairs, splits them into even/odd issue slots.
// Optional SPU_ISSUE_STATS_EN adds saturating dual/single issue counters.
//
//   state  | meaning
//   PAIR   | next issue starts a new pair at the FIFO head
//   SECOND | first word of head already issued, second word pending
module spu_issue_buffer
    import spu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr1,
    input  logic [31:0]     instr2,
    output logic            enable_pc,
    input  logic            branch_flush,
    input  logic [PC_W-1:0] branch_target,
    input  logic            issue_stall,
    output logic            even_valid,
    output logic [31:0]     even_instr,
    output logic [PC_W-1:0] even_pc,
    output logic            odd_valid,
    output logic [31:0]     odd_instr,
    output logic [PC_W-1:0] odd_pc
`ifdef SPU_ISSUE_STATS_EN
    ,
    output logic [15:0]     dual_cnt,
    output logic [15:0]     single_cnt
`endif
);

    issue_state_t    state_q, state_d;
    logic [PC_W-1:0] shadow_pc_q, shadow_pc_d;
    logic            skip_pend_q, skip_pend_d;

    logic            even_valid_q, even_valid_d;
    logic [31:0]     even_instr_q, even_instr_d;
    logic [PC_W-1:0] even_pc_q,    even_pc_d;
    logic            odd_valid_q,  odd_valid_d;
    logic [31:0]     odd_instr_q,  odd_instr_d;
    logic [PC_W-1:0] odd_pc_q,     odd_pc_d;

    pair_entry_t     head, push_entry;
    logic            fifo_full, fifo_empty, push, pop;
    logic [$clog2(DEPTH):0] fifo_count_unused;
    logic [PC_W-1:0] head_pc4;
    logic            can_dual, dual_fire, single_fire;
    logic            one_fire;
    logic [31:0]     one_instr;
    logic [PC_W-1:0] one_pc;

    assign enable_pc = ~fifo_full;
    assign push      = enable_pc & ~branch_flush;

    assign push_entry.first      = instr1;
    assign push_entry.second     = instr2;
    assign push_entry.pc         = shadow_pc_q;
    assign push_entry.skip_first = skip_pend_q;

    spu_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (branch_flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    assign head_pc4 = head.pc + PC_W'(4);
    assign can_dual = (state_q == PAIR) && !head.skip_first
                      && !is_odd_pipe(head.first) && is_odd_pipe(head.second)
                      && !depends_on(head.first, head.second);

    always_comb begin
        shadow_pc_d = shadow_pc_q;
        skip_pend_d = skip_pend_q;
        if (branch_flush) begin
            shadow_pc_d = {branch_target[PC_W-1:3], 3'b000};
            skip_pend_d = branch_target[2];
        end else if (push) begin
            shadow_pc_d = shadow_pc_q + PC_W'(8);
            skip_pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        dual_fire    = 1'b0;
        single_fire  = 1'b0;
        one_fire     = 1'b0;
        one_instr    = '0;
        one_pc       = '0;
        even_valid_d = even_valid_q;
        even_instr_d = even_instr_q;
        even_pc_d    = even_pc_q;
        odd_valid_d  = odd_valid_q;
        odd_instr_d  = odd_instr_q;
        odd_pc_d     = odd_pc_q;

        if (branch_flush) begin
            state_d      = PAIR;
            even_valid_d = 1'b0;
            odd_valid_d  = 1'b0;
        end else if (!issue_stall) begin
            even_valid_d = 1'b0;
            odd_valid_d  = 1'b0;
            if (!fifo_empty) begin
                case (state_q)
                    PAIR: begin
                        if (can_dual) begin
                            even_valid_d = 1'b1;
                            even_instr_d = head.first;
                            even_pc_d    = head.pc;
                            odd_valid_d  = 1'b1;
                            odd_instr_d  = head.second;
                            odd_pc_d     = head_pc4;
                            pop          = 1'b1;
                            dual_fire    = 1'b1;
                        end else if (head.skip_first) begin
                            one_fire  = 1'b1;
                            one_instr = head.second;
                            one_pc    = head_pc4;
                            pop       = 1'b1;
                        end else begin
                            one_fire  = 1'b1;
                            one_instr = head.first;
                            one_pc    = head.pc;
                            state_d   = SECOND;
                        end
                    end
                    SECOND: begin
                        one_fire  = 1'b1;
                        one_instr = head.second;
                        one_pc    = head_pc4;
                        pop       = 1'b1;
                        state_d   = PAIR;
                    end
                    default: state_d = PAIR;
                endcase
            end
            // A lone word goes to whichever slot its pipe class selects.
            if (one_fire) begin
                single_fire = 1'b1;
                if (is_odd_pipe(one_instr)) begin
                    odd_valid_d = 1'b1;
                    odd_instr_d = one_instr;
                    odd_pc_d    = one_pc;
                end else begin
                    even_valid_d = 1'b1;
                    even_instr_d = one_instr;
                    even_pc_d    = one_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= PAIR;
            shadow_pc_q  <= '0;
            skip_pend_q  <= 1'b0;
            even_valid_q <= 1'b0;
            even_instr_q <= '0;
            even_pc_q    <= '0;
            odd_valid_q  <= 1'b0;
            odd_instr_q  <= '0;
            odd_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            shadow_pc_q  <= shadow_pc_d;
            skip_pend_q  <= skip_pend_d;
            even_valid_q <= even_valid_d;
            even_instr_q <= even_instr_d;
            even_pc_q    <= even_pc_d;
            odd_valid_q  <= odd_valid_d;
            odd_instr_q  <= odd_instr_d;
            odd_pc_q     <= odd_pc_d;
        end
    end

    assign even_valid = even_valid_q;
    assign even_instr = even_instr_q;
    assign even_pc    = even_pc_q;
    assign odd_valid  = odd_valid_q;
    assign odd_instr  = odd_instr_q;
    assign odd_pc     = odd_pc_q;

`ifdef SPU_ISSUE_STATS_EN
    logic [15:0] dual_cnt_q, single_cnt_q;
    logic        unused_bits;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dual_cnt_q   <= '0;
            single_cnt_q <= '0;
        end else begin
            if (dual_fire && (dual_cnt_q != 16'hFFFF))
                dual_cnt_q <= dual_cnt_q + 16'd1;
            if (single_fire && (single_cnt_q != 16'hFFFF))
                single_cnt_q <= single_cnt_q + 16'd1;
        end
    end

    assign dual_cnt    = dual_cnt_q;
    assign single_cnt  = single_cnt_q;
    assign unused_bits = ^{branch_target[1:0], fifo_count_unused};
`else
    logic unused_bits;
    assign unused_bits = ^{branch_target[1:0], fifo_count_unused, dual_fire, single_fire};
`endif

endmodule

// File: tb/tb_spu_issue_buffer.sv
// Self-checking bench for spu_issue_buffer: directed table, corner sequences, random vs. model.
module tb_spu_issue_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr1, instr2;
    logic        enable_pc;
    logic        branch_flush;
    logic [10:0] branch_target;
    logic        issue_stall;
    logic        even_valid, odd_valid;
    logic [31:0] even_instr, odd_instr;
    logic [10:0] even_pc, odd_pc;
`ifdef SPU_ISSUE_STATS_EN
    logic [15:0] dual_cnt, single_cnt;
`endif

    spu_issue_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr1        (instr1),
        .instr2        (instr2),
        .enable_pc     (enable_pc),
        .branch_flush  (branch_flush),
        .branch_target (branch_target),
        .issue_stall   (issue_stall),
        .even_valid    (even_valid),
        .even_instr    (even_instr),
        .even_pc       (even_pc),
        .odd_valid     (odd_valid),
        .odd_instr     (odd_instr),
        .odd_pc        (odd_pc)
`ifdef SPU_ISSUE_STATS_EN
        ,
        .dual_cnt      (dual_cnt),
        .single_cnt    (single_cnt)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_EVEN = 32'h1C000081;
    localparam logic [31:0] A_ODD  = 32'h34000102;
    localparam logic [31:0] B_EVEN = 32'h1C000102;
    localparam logic [31:0] C_RT5  = 32'h1C000005;
    localparam logic [31:0] C_RA5  = 32'h34000280;

    // Reference model: each accepted pair is expanded at push time into the
    // issue bundles it will produce; a pair occupies buffer space until its last bundle issues.
    typedef struct {
        bit          ev;
        logic [31:0] ei;
        logic [10:0] ep;
        bit          ov;
        logic [31:0] oi;
        logic [10:0] op;
        bit          last;
    } bundle_t;

    bundle_t     bq[$];
    int          m_pairs;
    logic [10:0] m_pc;
    bit          m_skip;
    bundle_t     m_out;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic bit m_odd(logic [31:0] w);
        return w[31:29] == 3'b001;
    endfunction

    function automatic bundle_t one_word(logic [31:0] w, logic [10:0] pc, bit last);
        bundle_t x;
        x.ev = 0; x.ei = '0; x.ep = '0;
        x.ov = 0; x.oi = '0; x.op = '0;
        x.last = last;
        if (m_odd(w)) begin x.ov = 1; x.oi = w; x.op = pc; end
        else          begin x.ev = 1; x.ei = w; x.ep = pc; end
        return x;
    endfunction

    function automatic void add_pair(logic [31:0] a, logic [31:0] b, logic [10:0] pc, bit skip);
        bundle_t x;
        bit dep;
        logic [10:0] pc4;
        pc4 = pc + 11'd4;
        dep = (a[6:0] == b[13:7]) || (a[6:0] == b[20:14]);
        if (skip) begin
            bq.push_back(one_word(b, pc4, 1));
        end else if (!m_odd(a) && m_odd(b) && !dep) begin
            x.ev = 1; x.ei = a; x.ep = pc;
            x.ov = 1; x.oi = b; x.op = pc4;
            x.last = 1;
            bq.push_back(x);
        end else begin
            bq.push_back(one_word(a, pc, 0));
            bq.push_back(one_word(b, pc4, 1));
        end
    endfunction

    function automatic void model_reset();
        bq.delete();
        m_pairs = 0; m_pc = '0; m_skip = 0;
        m_out.ev = 0; m_out.ei = '0; m_out.ep = '0;
        m_out.ov = 0; m_out.oi = '0; m_out.op = '0;
        m_out.last = 0;
    endfunction

    function automatic void model_edge(logic [31:0] a, logic [31:0] b, bit fl, logic [10:0] tgt, bit st);
        bit en;
        bundle_t x;
        en = (m_pairs < DEPTH);
        if (fl) begin
            bq.delete();
            m_pairs = 0;
            m_out.ev = 0;
            m_out.ov = 0;
            m_pc = {tgt[10:3], 3'b000};
            m_skip = tgt[2];
            return;
        end
        if (!st) begin
            if (bq.size() > 0) begin
                x = bq.pop_front();
                m_out.ev = x.ev;
                m_out.ov = x.ov;
                if (x.ev) begin m_out.ei = x.ei; m_out.ep = x.ep; end
                if (x.ov) begin m_out.oi = x.oi; m_out.op = x.op; end
                if (x.last) m_pairs--;
            end else begin
                m_out.ev = 0;
                m_out.ov = 0;
            end
        end
        if (en) begin
            add_pair(a, b, m_pc, m_skip);
            m_pairs++;
            m_pc = m_pc + 11'd8;
            m_skip = 0;
        end
    endfunction

    // Called at a falling edge: drive, check enable, clock, then check outputs.
    task automatic cycle(logic [31:0] a, logic [31:0] b, bit fl, logic [10:0] tgt, bit st);
        instr1 = a; instr2 = b; branch_flush = fl; branch_target = tgt; issue_stall = st;
        chk("enable_pc", enable_pc, 32'(m_pairs < DEPTH));
        @(posedge clk);
        model_edge(a, b, fl, tgt, st);
        @(negedge clk);
        chk("even_valid", even_valid, 32'(m_out.ev));
        chk("odd_valid", odd_valid, 32'(m_out.ov));
        if (m_out.ev) begin
            chk("even_instr", even_instr, m_out.ei);
            chk("even_pc", even_pc, 32'(m_out.ep));
        end
        if (m_out.ov) begin
            chk("odd_instr", odd_instr, m_out.oi);
            chk("odd_pc", odd_pc, 32'(m_out.op));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_even_valid", even_valid, 32'd0);
        chk("rst_odd_valid", odd_valid, 32'd0);
        chk("rst_enable_pc", enable_pc, 32'd1);
        chk("rst_even_instr", even_instr, 32'd0);
        chk("rst_odd_pc", odd_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        w[31:28] = 4'($urandom_range(0, 5));
        w[6:0]   = 7'($urandom_range(0, 3));
        w[13:7]  = 7'($urandom_range(0, 3));
        w[20:14] = 7'($urandom_range(0, 3));
        return w;
    endfunction

    typedef struct {
        logic [31:0] i1, i2;
        bit          ev;
        logic [10:0] ep;
        bit          ov;
        logic [10:0] op;
        bit          en;
    } vec_t;

    vec_t tv[6];

    initial begin
        tv[0] = '{i1: A_EVEN, i2: A_ODD,  ev: 0, ep: 11'd0,  ov: 0, op: 11'd0,  en: 1};
        tv[1] = '{i1: A_EVEN, i2: B_EVEN, ev: 1, ep: 11'd0,  ov: 1, op: 11'd4,  en: 1};
        tv[2] = '{i1: C_RT5,  i2: C_RA5,  ev: 1, ep: 11'd8,  ov: 0, op: 11'd0,  en: 1};
        tv[3] = '{i1: A_EVEN, i2: A_ODD,  ev: 1, ep: 11'd12, ov: 0, op: 11'd0,  en: 1};
        tv[4] = '{i1: A_EVEN, i2: A_ODD,  ev: 1, ep: 11'd16, ov: 0, op: 11'd0,  en: 1};
        tv[5] = '{i1: A_EVEN, i2: A_ODD,  ev: 0, ep: 11'd0,  ov: 1, op: 11'd20, en: 1};

        instr1 = '0; instr2 = '0; branch_flush = 0; branch_target = '0; issue_stall = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        // Directed table: dual pair, even/even pair, dependent pair.
        for (int i = 0; i < 6; i++) begin
            cycle(tv[i].i1, tv[i].i2, 0, 11'd0, 0);
            chk($sformatf("tv%0d_even_valid", i), even_valid, 32'(tv[i].ev));
            chk($sformatf("tv%0d_odd_valid", i), odd_valid, 32'(tv[i].ov));
            if (tv[i].ev) chk($sformatf("tv%0d_even_pc", i), even_pc, 32'(tv[i].ep));
            if (tv[i].ov) chk($sformatf("tv%0d_odd_pc", i), odd_pc, 32'(tv[i].op));
            chk($sformatf("tv%0d_enable_pc", i), enable_pc, 32'(tv[i].en));
        end

        // Stall fills the buffer, then drains in order.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(A_EVEN, A_ODD, 0, 11'd0, 1);
        chk("stall_enable_low", enable_pc, 32'd0);
        chk("stall_even_frozen", even_valid, 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle(A_EVEN, A_ODD, 0, 11'd0, 0);
            chk("drain_even_valid", even_valid, 32'd1);
            chk("drain_even_pc", even_pc, 32'(k * 8));
            chk("drain_odd_pc", odd_pc, 32'(k * 8 + 4));
        end

        // Flush with 3 pairs buffered, target with bit 2 set.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(A_EVEN, A_ODD, 0, 11'd0, 1);
        cycle(A_EVEN, A_ODD, 1, 11'h014, 1);
        chk("flush_even_valid", even_valid, 32'd0);
        chk("flush_odd_valid", odd_valid, 32'd0);
        chk("flush_enable_pc", enable_pc, 32'd1);
        cycle(A_EVEN, A_ODD, 0, 11'd0, 0);
        chk("flush_empty_valid", even_valid | odd_valid, 32'd0);
        cycle(A_EVEN, A_ODD, 0, 11'd0, 0);
        chk("skip_even_valid", even_valid, 32'd0);
        chk("skip_odd_valid", odd_valid, 32'd1);
        chk("skip_odd_pc", odd_pc, 32'h014);
        chk("skip_odd_instr", odd_instr, A_ODD);

        // Async reset while the second word of a dependent pair is pending.
        do_reset();
        cycle(C_RT5, C_RA5, 0, 11'd0, 0);
        cycle(C_RT5, C_RA5, 0, 11'd0, 0);
        chk("mid_second_even_valid", even_valid, 32'd1);
        #2;
        do_reset();
        cycle(A_EVEN, A_ODD, 0, 11'd0, 0);
        cycle(A_EVEN, A_ODD, 0, 11'd0, 0);
        chk("post_reset_even_pc", even_pc, 32'd0);
        chk("post_reset_odd_pc", odd_pc, 32'd4);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle(rand_instr(), rand_instr(), ($urandom_range(0, 24) == 0),
                  11'($urandom), ($urandom_range(0, 9) < 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
